// File: rtl/core_op_ctrl_if.sv
// Command, input-load, display-read and engine-control signals of the HW3 operation sequencer.
// master = command/host side, slave = core_op_ctrl.
interface core_op_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              i_op_valid;
  logic [3:0]        i_op_mode;
  logic              o_op_ready;
  logic              i_in_valid;
  logic              o_in_ready;
  logic              o_load_we;
  logic [ADDR_W-1:0] o_load_addr;
  logic              o_disp_re;
  logic [ADDR_W-1:0] o_disp_addr;
  logic              o_disp_last;
  logic              o_eng_start;
  logic [1:0]        o_eng_sel;
  logic              i_eng_done;
  logic [2:0]        o_origin_x;
  logic [2:0]        o_origin_y;
  logic [5:0]        o_depth;

  modport master (
    output i_op_valid, i_op_mode, i_in_valid, i_eng_done,
    input  o_op_ready, o_in_ready, o_load_we, o_load_addr,
           o_disp_re, o_disp_addr, o_disp_last,
           o_eng_start, o_eng_sel, o_origin_x, o_origin_y, o_depth
  );

  modport slave (
    input  i_op_valid, i_op_mode, i_in_valid, i_eng_done,
    output o_op_ready, o_in_ready, o_load_we, o_load_addr,
           o_disp_re, o_disp_addr, o_disp_last,
           o_eng_start, o_eng_sel, o_origin_x, o_origin_y, o_depth
  );
endinterface

// File: rtl/core_op_ctrl.sv
// Operation sequencer for the HW3 image core: command handshake, map load, display
// window addressing and engine launch. No pixel datapath lives here.
module core_op_ctrl #(
  parameter int ADDR_W = 11,
  parameter int N_LOAD = 2048,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  core_op_ctrl_if.slave io_if
);

  typedef enum logic [2:0] {
    S_RDY, S_WAIT, S_LOAD, S_UPD, S_DISP, S_DRAIN, S_ESTART, S_EWAIT
  } state_t;

  state_t            r_state;
  logic              r_op_ready;
  logic              r_in_ready;
  logic              r_disp_re;
  logic              r_disp_last;
  logic              r_eng_start;
  logic [1:0]        r_eng_sel;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [3:0]        r_mode;
  logic [2:0]        r_x;
  logic [2:0]        r_y;
  logic [5:0]        r_depth;
  logic [4:0]        r_ch;
  logic [1:0]        r_q;
  logic [7:0]        r_drain;

  logic              w_accept;
  logic [4:0]        w_ch_n;
  logic [1:0]        w_q_n;
  logic              w_last_n;
  logic [ADDR_W-1:0] w_addr_n;

  // q = {dy,dx}; x+dx and y+dy never exceed 7, so the address is a plain bit concat.
  function automatic logic [ADDR_W-1:0] f_disp_addr(input logic [4:0] ch, input logic [1:0] q,
                                                    input logic [2:0] x, input logic [2:0] y);
    logic [2:0] px;
    logic [2:0] py;
    px = x + {2'b00, q[0]};
    py = y + {2'b00, q[1]};
    return ADDR_W'({ch, py, px});
  endfunction

  always_comb begin
    w_accept = io_if.i_in_valid & r_in_ready;
    w_q_n    = r_q + 2'd1;
    w_ch_n   = (r_q == 2'd3) ? r_ch + 5'd1 : r_ch;
    w_last_n = ({1'b0, w_ch_n} == r_depth - 6'd1) && (w_q_n == 2'd3);
    w_addr_n = f_disp_addr(w_ch_n, w_q_n, r_x, r_y);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_RDY;
      r_op_ready  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_disp_re   <= 1'b0;
      r_disp_last <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_sel   <= '0;
      r_cnt       <= '0;
      r_disp_addr <= '0;
      r_mode      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_depth     <= 6'd32;
      r_ch        <= '0;
      r_q         <= '0;
      r_drain     <= '0;
    end else begin
      case (r_state)
        // Other states raise the strobe as they enter RDY; straight out of reset it is
        // still low, so RDY holds one extra cycle to emit the pulse.
        S_RDY: begin
          if (r_op_ready) begin
            r_op_ready <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_op_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (io_if.i_op_valid) begin
            r_mode <= io_if.i_op_mode;
            case (io_if.i_op_mode)
              4'd0: begin
                r_in_ready <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_LOAD;
              end
              4'd7: begin
                r_ch        <= '0;
                r_q         <= '0;
                r_disp_re   <= 1'b1;
                r_disp_last <= 1'b0;
                r_disp_addr <= f_disp_addr(5'd0, 2'd0, r_x, r_y);
                r_state     <= S_DISP;
              end
              4'd8, 4'd9, 4'd10: begin
                r_eng_start <= 1'b1;
                r_eng_sel   <= io_if.i_op_mode[1:0];
                r_state     <= S_ESTART;
              end
              default: r_state <= S_UPD;
            endcase
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_cnt == ADDR_W'(N_LOAD - 1)) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_op_ready <= 1'b1;
              r_state    <= S_RDY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_UPD: begin
          case (r_mode)
            4'd1: if (r_x != 3'd6) r_x <= r_x + 3'd1;
            4'd2: if (r_x != 3'd0) r_x <= r_x - 3'd1;
            4'd3: if (r_y != 3'd0) r_y <= r_y - 3'd1;
            4'd4: if (r_y != 3'd6) r_y <= r_y + 3'd1;
            4'd5: if (r_depth == 6'd32) r_depth <= 6'd16;
                  else if (r_depth == 6'd16) r_depth <= 6'd8;
            4'd6: if (r_depth == 6'd8) r_depth <= 6'd16;
                  else if (r_depth == 6'd16) r_depth <= 6'd32;
            default: ;
          endcase
          r_op_ready <= 1'b1;
          r_state    <= S_RDY;
        end
        S_DISP: begin
          if (r_disp_last) begin
            r_disp_re   <= 1'b0;
            r_disp_last <= 1'b0;
            r_drain     <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_ch        <= w_ch_n;
            r_q         <= w_q_n;
            r_disp_addr <= w_addr_n;
            r_disp_last <= w_last_n;
          end
        end
        S_DRAIN: begin
          if (r_drain == 8'(RD_LAT - 1)) begin
            r_op_ready <= 1'b1;
            r_state    <= S_RDY;
          end else begin
            r_drain <= r_drain + 8'd1;
          end
        end
        S_ESTART: begin
          r_eng_start <= 1'b0;
          r_state     <= S_EWAIT;
        end
        S_EWAIT: begin
          if (io_if.i_eng_done) begin
            r_op_ready <= 1'b1;
            r_state    <= S_RDY;
          end
        end
        default: r_state <= S_RDY;
      endcase
    end
  end

  assign io_if.o_op_ready  = r_op_ready;
  assign io_if.o_in_ready  = r_in_ready;
  assign io_if.o_load_we   = w_accept;
  assign io_if.o_load_addr = r_cnt;
  assign io_if.o_disp_re   = r_disp_re;
  assign io_if.o_disp_addr = r_disp_addr;
  assign io_if.o_disp_last = r_disp_last;
  assign io_if.o_eng_start = r_eng_start;
  assign io_if.o_eng_sel   = r_eng_sel;
  assign io_if.o_origin_x  = r_x;
  assign io_if.o_origin_y  = r_y;
  assign io_if.o_depth     = r_depth;

endmodule

// File: tb/tb_core_op_ctrl.sv
// Scoreboard bench for core_op_ctrl: load/display address streams are queued at command
// issue and checked as the DUT emits them; origin/depth follow a saturating model.
module tb_core_op_ctrl;
  localparam int ADDR_W = 11;
  localparam int N_LOAD = 2048;
  localparam int RD_LAT = 1;

  typedef struct {
    int unsigned addr;
    int unsigned last;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_op_ctrl_if #(.ADDR_W(ADDR_W)) io_if ();

  core_op_ctrl #(.ADDR_W(ADDR_W), .N_LOAD(N_LOAD), .RD_LAT(RD_LAT)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_if (io_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int mx = 0, my = 0, md = 32;
  int n_start = 0;
  int unsigned exp_sel = 0;
  int unsigned q_load[$];
  rd_t q_disp[$];
  rd_t mon_e;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor, sampled between the driving negedge and the next active edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (io_if.o_load_we) begin
        if (q_load.size() == 0) chk("load_extra", io_if.o_load_addr, 99999);
        else chk("load_addr", io_if.o_load_addr, q_load.pop_front());
      end
      if (io_if.o_disp_re) begin
        if (q_disp.size() == 0) chk("disp_extra", io_if.o_disp_addr, 99999);
        else begin
          mon_e = q_disp.pop_front();
          chk("disp_addr", io_if.o_disp_addr, mon_e.addr);
          chk("disp_last", io_if.o_disp_last, mon_e.last);
        end
      end
      if (io_if.o_eng_start) begin
        n_start++;
        chk("eng_sel", io_if.o_eng_sel, exp_sel);
      end
    end
  end

  task automatic issue(input int mode, input int budget, output int lat);
    @(negedge clk);
    io_if.i_op_valid = 1'b1;
    io_if.i_op_mode  = 4'(mode);
    lat = 0;
    do begin
      @(negedge clk);
      io_if.i_op_valid = 1'b0;
      lat++;
    end while (!io_if.o_op_ready && lat < budget);
    chk($sformatf("op_ready_m%0d", mode), io_if.o_op_ready, 1);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_x"}, io_if.o_origin_x, mx);
    chk({tag, "_y"}, io_if.o_origin_y, my);
    chk({tag, "_depth"}, io_if.o_depth, md);
  endtask

  task automatic upd(input int mode);
    int lat;
    case (mode)
      1: if (mx < 6) mx++;
      2: if (mx > 0) mx--;
      3: if (my > 0) my--;
      4: if (my < 6) my++;
      5: if (md > 8) md = md / 2;
      6: if (md < 32) md = md * 2;
      default: ;
    endcase
    issue(mode, 10, lat);
    chk($sformatf("upd_lat_m%0d", mode), lat, 2);
    chk_regs($sformatf("upd_m%0d", mode));
  endtask

  task automatic do_load(input int n_stop);
    int acc = 0;
    int cyc = 0;
    bit v;
    for (int a = 0; a < N_LOAD; a++) q_load.push_back(a);
    @(negedge clk);
    io_if.i_op_valid = 1'b1;
    io_if.i_op_mode  = 4'd0;
    @(negedge clk);
    io_if.i_op_valid = 1'b0;
    chk("in_ready_on", io_if.o_in_ready, 1);
    while (acc < n_stop && cyc < 4 * N_LOAD) begin
      v = ($urandom_range(0, 3) != 0);
      io_if.i_in_valid = v;
      if (v && io_if.o_in_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    io_if.i_in_valid = 1'b0;
    chk("load_accepts", acc, n_stop);
    if (n_stop == N_LOAD) begin
      chk("load_done_rdy", io_if.o_op_ready, 1);
      chk("load_in_ready_off", io_if.o_in_ready, 0);
      chk("load_q_empty", q_load.size(), 0);
    end
  endtask

  task automatic disp();
    int lat;
    rd_t e;
    for (int ch = 0; ch < md; ch++)
      for (int q = 0; q < 4; q++) begin
        e.addr = ch * 64 + (my + q / 2) * 8 + mx + (q % 2);
        e.last = (ch == md - 1 && q == 3) ? 1 : 0;
        q_disp.push_back(e);
      end
    issue(7, 4 * md + 20, lat);
    chk("disp_lat", lat, 4 * md + 1 + RD_LAT);
    chk("disp_q_empty", q_disp.size(), 0);
  endtask

  task automatic eng(input int mode);
    int s0 = n_start;
    int early = 0;
    exp_sel = mode - 8;
    @(negedge clk);
    io_if.i_op_valid = 1'b1;
    io_if.i_op_mode  = 4'(mode);
    @(negedge clk);
    io_if.i_op_valid = 1'b0;
    io_if.i_eng_done = 1'b1;
    chk("eng_start_on", io_if.o_eng_start, 1);
    @(negedge clk);
    io_if.i_eng_done = 1'b0;
    chk("eng_start_off", io_if.o_eng_start, 0);
    repeat (100) begin
      @(negedge clk);
      if (io_if.o_op_ready) early++;
    end
    chk("eng_early_ready", early, 0);
    chk("eng_sel_hold", io_if.o_eng_sel, mode - 8);
    io_if.i_eng_done = 1'b1;
    @(negedge clk);
    io_if.i_eng_done = 1'b0;
    chk("eng_done_rdy", io_if.o_op_ready, 1);
    chk("eng_n_start", n_start - s0, 1);
  endtask

  task automatic post_reset(input string tag);
    @(negedge clk);
    chk({tag, "_rdy_pulse"}, io_if.o_op_ready, 1);
    @(negedge clk);
    chk({tag, "_rdy_once"}, io_if.o_op_ready, 0);
    chk_regs(tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io_if.i_op_valid = 1'b0;
    io_if.i_op_mode  = '0;
    io_if.i_in_valid = 1'b0;
    io_if.i_eng_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", io_if.o_op_ready, 0);
    chk("rst_in_ready", io_if.o_in_ready, 0);
    chk("rst_disp_re", io_if.o_disp_re, 0);
    chk("rst_eng_start", io_if.o_eng_start, 0);
    chk_regs("rst");
    rst = 1'b0;
    post_reset("boot");

    // T1
    do_load(N_LOAD);

    // T2
    repeat (7) upd(1);
    repeat (7) upd(4);
    repeat (8) upd(2);
    repeat (8) upd(3);

    // T3
    repeat (6) upd(1);
    repeat (6) upd(4);
    repeat (2) upd(5);
    disp();

    // T4
    repeat (2) upd(6);
    repeat (3) upd(5);
    disp();
    repeat (3) upd(6);
    disp();

    // T5
    eng(9);
    eng(8);
    eng(10);
    chk_regs("after_eng");

    // T6
    upd(12);
    upd(15);
    do_load(500);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q_load.delete();
    rst = 1'b0;
    mx = 0;
    my = 0;
    md = 32;
    post_reset("midload");
    do_load(N_LOAD);
    chk_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
